// File: rtl/spi_slave_shift.sv
// spi_slave_shift: SPI target shift engine.
// Oversamples SCLK/CS_N/MOSI in the clk_in domain, deserialises MOSI into
// rx words and serialises a host-supplied tx word onto MISO. Supports all four
// cpol/cpha modes and MSB- or LSB-first bit order.
// Optional: define SPI_SLAVE_ERR_EN to add sticky rx_overrun/tx_underrun flags
// (cleared by err_clr, set wins) and the rx_ready_i input.
module spi_slave_shift #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk_in,
   input  logic                  rst,
   input  logic                  cpol,
   input  logic                  cpha,
   input  logic                  lsb_first,
   input  logic                  spi_sclk,
   input  logic                  spi_cs_n,
   input  logic                  spi_mosi,
   output logic                  spi_miso,
   output logic                  spi_miso_oe,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy
`ifdef SPI_SLAVE_ERR_EN
   ,
   input  logic                  rx_ready_i,
   input  logic                  err_clr,
   output logic                  rx_overrun,
   output logic                  tx_underrun
`endif
);

   localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

   state_e                  state_q;
   logic [SYNC_STAGES-1:0]  sclk_sync_q, cs_sync_q, mosi_sync_q;
   logic                    sclk_hist_q, cs_hist_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [DATA_WIDTH-1:0]   shreg_q, rx_shift_q, rx_data_q, hold_q;
   logic                    hold_full_q, rx_valid_q;

   logic                    sclk_s, cs_s, mosi_s;
   logic                    cs_fall, cs_rise, edges_en;
   logic                    lead_edge, trail_edge, sample_edge, shift_edge;
   logic                    tx_write, load;
   logic [DATA_WIDTH-1:0]   load_word, shreg_adv, rx_word_d;

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s   = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   // Synchronise the asynchronous SPI pins and keep one history bit for edges.
   // NOTE: these flops are deliberately not reset, so a reset taken while CS is
   // held low cannot manufacture a false CS falling edge afterwards.
   always_ff @(posedge clk_in) begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_hist_q <= sclk_s;
      cs_hist_q   <= cs_s;
   end

   // Edge classification, load-point decision and next shift/receive values.
   // NOTE: every signal written here is given a value on every path, so no
   // latch can be inferred.
   always_comb begin
      cs_fall     = cs_hist_q & ~cs_s;
      cs_rise     = ~cs_hist_q & cs_s;
      edges_en    = (state_q == ACTIVE) && !cs_rise;
      lead_edge   = (sclk_hist_q == cpol) && (sclk_s != cpol);
      trail_edge  = (sclk_hist_q != cpol) && (sclk_s == cpol);
      sample_edge = edges_en && (cpha ? trail_edge : lead_edge);
      shift_edge  = edges_en && (cpha ? lead_edge : trail_edge);
      tx_write    = tx_valid && !hold_full_q;
      // A shift edge with the counter at zero is the first shift edge of a
      // word (cpha=1) or the one right after a completed word (cpha=0).
      load        = ((state_q == IDLE) && cs_fall && !cpha) ||
                    (shift_edge && (cnt_q == '0));
      load_word   = hold_full_q ? hold_q : (tx_write ? tx_data : '1);
      shreg_adv   = lsb_first ? {1'b1, shreg_q[DATA_WIDTH-1:1]}
                              : {shreg_q[DATA_WIDTH-2:0], 1'b1};
      rx_word_d   = lsb_first ? {mosi_s, rx_shift_q[DATA_WIDTH-1:1]}
                              : {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
   end

   // Tx holding register: filled by the host, emptied by a shift-register load.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         hold_q      <= '0;
         hold_full_q <= 1'b0;
      end else begin
         if (tx_write) hold_q <= tx_data;
         // A load with an empty slot takes tx_data directly, so the slot stays empty.
         hold_full_q <= load ? 1'b0 : (hold_full_q | tx_write);
      end
   end

   // Frame FSM with bit counter, tx shift register and rx assembly.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register sees the pre-edge values of the others.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         shreg_q    <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cs_fall) begin
                  state_q    <= ACTIVE;
                  cnt_q      <= '0;
                  rx_shift_q <= '0;
               end
               if (load) shreg_q <= load_word;
            end
            ACTIVE: begin
               if (cs_rise) begin
                  state_q    <= IDLE;
                  cnt_q      <= '0;
                  shreg_q    <= '0;
                  rx_shift_q <= '0;
               end else begin
                  if (sample_edge) begin
                     rx_shift_q <= rx_word_d;
                     if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        cnt_q      <= '0;
                        rx_data_q  <= rx_word_d;
                        rx_valid_q <= 1'b1;
                     end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                     end
                  end
                  if (shift_edge) shreg_q <= load ? load_word : shreg_adv;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy        = (state_q == ACTIVE);
   assign spi_miso_oe = busy;
   assign spi_miso    = busy && (lsb_first ? shreg_q[0] : shreg_q[DATA_WIDTH-1]);
   assign tx_ready    = !hold_full_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;

`ifdef SPI_SLAVE_ERR_EN
   logic underrun_evt;
   assign underrun_evt = load && !hold_full_q && !tx_write;

   // Sticky error flags; a set event in the same cycle as err_clr wins.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         rx_overrun  <= 1'b0;
         tx_underrun <= 1'b0;
      end else begin
         rx_overrun  <= (rx_valid_q && !rx_ready_i) || (rx_overrun && !err_clr);
         tx_underrun <= underrun_evt || (tx_underrun && !err_clr);
      end
   end
`endif

endmodule

// File: tb/tb_spi_slave_shift.sv
// Testbench for spi_slave_shift: directed and randomised SPI frames driven by
// a bit-level master model; expected MISO/rx words come from a word-level model.
module tb_spi_slave_shift;

   localparam int W = 8;
   localparam int H = 8;   // SCLK half period in clk_in cycles

   logic         clk_in = 1'b0;
   logic         rst;
   logic         cpol, cpha, lsb_first;
   logic         spi_sclk, spi_cs_n, spi_mosi;
   logic         spi_miso, spi_miso_oe;
   logic [W-1:0] tx_data;
   logic         tx_valid, tx_ready;
   logic [W-1:0] rx_data;
   logic         rx_valid, busy;
`ifdef SPI_SLAVE_ERR_EN
   logic         rx_ready_i, err_clr, rx_overrun, tx_underrun;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   logic [W-1:0] mosi_w   [0:3];
   logic [W-1:0] tx_w     [0:3];
   bit           tx_have  [0:3];
   logic [W-1:0] miso_got [0:3];
   logic [W-1:0] rx_q     [$];

   spi_slave_shift #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
      .clk_in      (clk_in),
      .rst         (rst),
      .cpol        (cpol),
      .cpha        (cpha),
      .lsb_first   (lsb_first),
      .spi_sclk    (spi_sclk),
      .spi_cs_n    (spi_cs_n),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .spi_miso_oe (spi_miso_oe),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .busy        (busy)
`ifdef SPI_SLAVE_ERR_EN
      ,
      .rx_ready_i  (rx_ready_i),
      .err_clr     (err_clr),
      .rx_overrun  (rx_overrun),
      .tx_underrun (tx_underrun)
`endif
   );

   always #5 clk_in = ~clk_in;

   // Record every rx word the DUT announces; a stretched pulse shows up as extras.
   always @(negedge clk_in) begin
      if (rx_valid === 1'b1) rx_q.push_back(rx_data);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   function automatic logic bit_of(input logic [W-1:0] w, input int i, input logic lsb);
      return lsb ? w[i] : w[W-1-i];
   endfunction

   task automatic tx_write(input logic [W-1:0] w);
      @(negedge clk_in);
      check("tx_ready_before_write", tx_ready, 1);
      tx_data  = w;
      tx_valid = 1'b1;
      @(negedge clk_in);
      tx_valid = 1'b0;
      check("tx_ready_after_write", tx_ready, 0);
   endtask

   task automatic pulse_reset_and_check();
      @(negedge clk_in);
      rst = 1'b1;
      @(negedge clk_in);
      rst = 1'b0;
      check("rst_miso", spi_miso, 0);
      check("rst_miso_oe", spi_miso_oe, 0);
      check("rst_tx_ready", tx_ready, 1);
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_busy", busy, 0);
   endtask

   // Drive one CS-low frame. abort_bits>0 raises CS after that many bits;
   // rst_bit>=0 pulses reset (with a pending tx word) just before that bit.
   task automatic spi_frame(input logic pol, input logic pha, input logic lsb,
                            input int nwords, input int abort_bits, input int rst_bit);
      int nbits, k, i, pos;
      logic [W-1:0] exp_miso;
      nbits = (abort_bits > 0) ? abort_bits : nwords * W;
      cpol = pol; cpha = pha; lsb_first = lsb; spi_sclk = pol;
      wait_clk(2 * H);
      rx_q.delete();
      for (int j = 0; j < 4; j++) miso_got[j] = '0;
      if (!pha) spi_mosi = bit_of(mosi_w[0], 0, lsb);
      spi_cs_n = 1'b0;
      wait_clk(H);
      for (int b = 0; b < nbits; b++) begin
         k = b / W; i = b % W; pos = lsb ? i : W - 1 - i;
         if (b == rst_bit) begin
            tx_write(8'h77);
            pulse_reset_and_check();
         end
         if (b == 0 && rst_bit < 0) begin
            check("busy_in_frame", busy, 1);
            check("miso_oe_in_frame", spi_miso_oe, 1);
         end
         if (!pha) begin
            miso_got[k][pos] = spi_miso;
            spi_sclk = ~pol;
            wait_clk(H);
            spi_sclk = pol;
            if (b + 1 < nbits) spi_mosi = bit_of(mosi_w[(b + 1) / W], (b + 1) % W, lsb);
            if (i == 3 && k + 1 < nwords && tx_have[k + 1]) tx_write(tx_w[k + 1]);
            wait_clk(H);
         end else begin
            spi_sclk = ~pol;
            spi_mosi = bit_of(mosi_w[k], i, lsb);
            if (i == 3 && k + 1 < nwords && tx_have[k + 1]) tx_write(tx_w[k + 1]);
            wait_clk(H);
            miso_got[k][pos] = spi_miso;
            spi_sclk = pol;
            wait_clk(H);
         end
         if (rst_bit >= 0 && b >= rst_bit) check("busy_after_rst", busy, 0);
      end
      spi_cs_n = 1'b1;
      wait_clk(H);
      if (abort_bits > 0) begin
         check("abort_rx_count", rx_q.size(), 0);
      end else begin
         check("rx_count", rx_q.size(), nwords);
         for (int j = 0; j < nwords; j++) begin
            exp_miso = tx_have[j] ? tx_w[j] : '1;
            check($sformatf("miso_word%0d", j), miso_got[j], exp_miso);
            if (j < rx_q.size()) check($sformatf("rx_word%0d", j), rx_q[j], mosi_w[j]);
         end
         check("tx_ready_end", tx_ready, 1);
      end
      check("busy_end", busy, 0);
      check("miso_oe_end", spi_miso_oe, 0);
      check("miso_end", spi_miso, 0);
   endtask

   initial begin
      logic p, a, l;
      int   nw;
      rst = 1'b1; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
      spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
      tx_data = '0; tx_valid = 1'b0;
`ifdef SPI_SLAVE_ERR_EN
      rx_ready_i = 1'b1; err_clr = 1'b0;
`endif
      wait_clk(4);
      check("reset_miso", spi_miso, 0);
      check("reset_miso_oe", spi_miso_oe, 0);
      check("reset_tx_ready", tx_ready, 1);
      check("reset_rx_data", rx_data, 0);
      check("reset_rx_valid", rx_valid, 0);
      check("reset_busy", busy, 0);
      rst = 1'b0;
      wait_clk(4);

      // Mode 0, MSB first: tx 0xA5, master sends 0x3C.
      tx_w[0] = 8'hA5; tx_have[0] = 1; mosi_w[0] = 8'h3C;
      tx_write(tx_w[0]);
      spi_frame(1'b0, 1'b0, 1'b0, 1, 0, -1);

      // Mode 3, LSB first: tx 0x81, master sends 0x01.
      tx_w[0] = 8'h81; tx_have[0] = 1; mosi_w[0] = 8'h01;
      tx_write(tx_w[0]);
      spi_frame(1'b1, 1'b1, 1'b1, 1, 0, -1);

      // Two back-to-back words, second tx written while the first shifts.
      tx_w[0] = 8'h11; tx_have[0] = 1; tx_w[1] = 8'h22; tx_have[1] = 1;
      mosi_w[0] = 8'hC3; mosi_w[1] = 8'h5E;
      tx_write(tx_w[0]);
      spi_frame(1'b0, 1'b0, 1'b0, 2, 0, -1);

      // Underrun: nothing written before CS falls.
      tx_have[0] = 0; mosi_w[0] = 8'h96;
      spi_frame(1'b0, 1'b0, 1'b0, 1, 0, -1);
`ifdef SPI_SLAVE_ERR_EN
      check("tx_underrun_set", tx_underrun, 1);
      @(negedge clk_in); err_clr = 1'b1;
      @(negedge clk_in); err_clr = 1'b0;
      check("tx_underrun_clr", tx_underrun, 0);
      check("rx_overrun_idle", rx_overrun, 0);
`endif

      // CS raised after 5 bits, then a clean frame.
      tx_have[0] = 0; mosi_w[0] = 8'hFF;
      spi_frame(1'b0, 1'b1, 1'b0, 1, 5, -1);
      tx_w[0] = 8'h3A; tx_have[0] = 1; mosi_w[0] = 8'h6B;
      tx_write(tx_w[0]);
      spi_frame(1'b0, 1'b1, 1'b0, 1, 0, -1);

      // Reset mid-word with CS held low; DUT must stay idle until a fresh CS fall.
      tx_have[0] = 0; mosi_w[0] = 8'hE7;
      spi_frame(1'b0, 1'b0, 1'b0, 1, 6, 3);
      tx_w[0] = 8'hC9; tx_have[0] = 1; mosi_w[0] = 8'h24;
      tx_write(tx_w[0]);
      spi_frame(1'b0, 1'b0, 1'b1, 1, 0, -1);

      // Randomised frames over all modes and bit orders.
      for (int r = 0; r < 6; r++) begin
         p  = 1'($urandom_range(0, 1));
         a  = 1'($urandom_range(0, 1));
         l  = 1'($urandom_range(0, 1));
         nw = $urandom_range(1, 3);
         for (int j = 0; j < 4; j++) begin
            mosi_w[j]  = 8'($urandom);
            tx_w[j]    = 8'($urandom);
            tx_have[j] = ($urandom_range(0, 3) != 0);
         end
         if (tx_have[0]) tx_write(tx_w[0]);
         spi_frame(p, a, l, nw, 0, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
